bless_inject_queue: RTL and testbench
=====================================

# bless_inject_queue

Local-node injection buffer sitting directly upstream of the bufferless router's local port (port 4). Accepts flits from the node/core side into a small FIFO and presents the head flit on the router's port-4 control/data inputs only in cycles where the router's combinational `port4_ready` grants injection. Decouples core issue timing from deflection-network availability and never presents a flit the router cannot take.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `PTR_W`, 2: log2(`DEPTH`).
- `STARVE_MAX`, 255: saturation value of the starvation counter (only with `BLESS_INJ_STARVE_EN`).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `core_ci` in `control_w`: flit control word from core; the `valid_f` bit is ignored and regenerated.
- `core_di` in `data_w`: flit payload from core.
- `core_valid` in 1: core offers a flit.
- `core_ready` out 1: `~full`; push occurs when `core_valid & core_ready`.
- `port4_ready` in 1: router grants local injection this cycle; combinational from router stage-1 inputs.
- `port4_ci` out `control_w`: to router port-4 control input.
- `port4_di` out `data_w`: to router port-4 data input.
- `inj_fire` out 1: head flit consumed this cycle.
- `occupancy` out `PTR_W+1`: number of stored flits.
- `starve_cnt` out 8: consecutive denied cycles (macro only).
- `starved` out 1: `starve_cnt == STARVE_MAX` (macro only).

## Operation
- Circular FIFO: `wr_ptr` and `rd_ptr` (`PTR_W` bits, wrap modulo `DEPTH`), `count` (`PTR_W+1` bits, 0..`DEPTH`).
- `full = (count == DEPTH)`, `empty = (count == 0)`.
- `push = core_valid & ~full`; `pop = port4_ready & ~empty & rst`; `inj_fire = pop`.
- `port4_ci` = head control with `valid_f` forced to 1 when `pop`; otherwise all-zero `control_w`. `port4_di` = head data when `pop`, otherwise zero. The router latches port 4 unconditionally every cycle, so a non-granted head must never appear valid; the head is re-presented in later cycles (no duplication, no loss).
- Push and pop in the same cycle: both occur, `count` unchanged, and the pop returns the old head. When empty, there is no bypass: a pushed flit is injectable from the next cycle at the earliest.
- Full: `core_ready` = 0. A pop in that cycle does not enable a push in the same cycle; `core_ready` depends only on `count`.
- Flits leave in strict arrival order.
- Reset (`rst` low, any time): pointers, `count`, and the starvation counter clear asynchronously. Stored flits are discarded. `port4_ci` and `port4_di` are zero and `core_ready` is 0 while `rst` is low. Reset values: `core_ready` = 0 during reset and 1 after release; `inj_fire` 0; `occupancy` 0; `starve_cnt` 0; `starved` 0.

## Timing
- Push to earliest injection: 1 cycle. A flit pushed at edge N is presented with `valid_f` = 1 in cycle N+1 if `port4_ready` is high.
- `port4_ready` → `port4_ci.valid_f`, `inj_fire` is a combinational path. No combinational path from `core_*` to `port4_*`.
- Full throughput: 1 push and 1 pop per cycle.

## Configuration
- `BLESS_INJ_STARVE_EN` defined:
  - `starve_cnt` increments each cycle with `~empty & ~port4_ready`.
  - It clears on `pop` or when empty, and saturates at `STARVE_MAX`.
  - `starved` is asserted while saturated. It drives future starvation-throttle logic.
- Undefined: `starve_cnt` and `starved` are tied to 0, with no counter registers.

## Structure
- Shared defines file (already holds `control_w`, `data_w`, `control_n`, `valid_f`) gains `` `inj_depth `` and `` `inj_starve_max `` defaults.
- One sub-module, `inj_fifo`: parameterized storage, pointers and count, with `push`/`pop`/`full`/`empty`/head outputs. Valid masking, handshake and starvation logic stay in the top.

## Test plan
- Reset release, empty queue, `port4_ready`=1 → `port4_ci`=0, `inj_fire`=0, `core_ready`=1, `occupancy`=0.
- Push flit A (data 0xA5) with `port4_ready`=1 every cycle → A appears on `port4_di` one cycle after push with `valid_f`=1, `inj_fire`=1 for exactly one cycle.
- Push 4 flits with `port4_ready`=0 → `occupancy`=4, `core_ready`=0, `port4_ci`=0 throughout. Raise ready → flits leave in order over 4 consecutive cycles, and `core_ready` returns high after the first pop.
- Occupancy 2, simultaneous push and pop → `occupancy` stays 2, oldest flit injected, ordering preserved across pointer wrap (≥6 flits through `DEPTH`=4).
- `rst` driven low mid-burst with 3 stored flits → outputs zero immediately (asynchronously). After release, `occupancy`=0 and no stale flit is ever injected.
- With `BLESS_INJ_STARVE_EN`: 1 flit queued, `port4_ready`=0 for 300 cycles → `starve_cnt` reaches 255 at cycle 255 and holds, `starved`=1. One granted cycle → `starve_cnt`=0, `starved`=0.

Source files
------------

// File: rtl/bless_inject_queue_pkg.sv
// -----------------------------------------------------------------------------
// bless_inject_queue_pkg
//
// Shared widths, field positions and defaults for the local-node injection
// queue that feeds port 4 of the bufferless (BLESS) router.
//
//   CONTROL_W      : width of a flit control word
//   DATA_W         : width of a flit payload
//   VALID_F        : bit index of the valid flag inside the control word
//   INJ_DEPTH      : default injection FIFO depth (power of two, >= 2)
//   INJ_PTR_W      : log2(INJ_DEPTH)
//   INJ_STARVE_MAX : default saturation value of the starvation counter
//   STARVE_W       : width of the starvation counter output
// -----------------------------------------------------------------------------
package bless_inject_queue_pkg;

  localparam int CONTROL_W      = 8;
  localparam int DATA_W         = 32;
  localparam int VALID_F        = 0;

  localparam int INJ_DEPTH      = 4;
  localparam int INJ_PTR_W      = 2;
  localparam int INJ_STARVE_MAX = 255;
  localparam int STARVE_W       = 8;

  localparam int FLIT_W         = CONTROL_W + DATA_W;

  // One stored flit: control word in the upper bits, payload below.
  typedef struct packed {
    logic [CONTROL_W-1:0] ctrl;
    logic [DATA_W-1:0]    data;
  } flit_t;

  // Regenerates the valid flag of a control word. The core's own valid bit
  // carries no meaning once the flit is queued, so it is simply overwritten.
  function automatic logic [CONTROL_W-1:0] set_valid(input logic [CONTROL_W-1:0] ctrl);
    logic [CONTROL_W-1:0] res;
    res          = ctrl;
    res[VALID_F] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/bless_inject_queue_inj_fifo.sv
// -----------------------------------------------------------------------------
// bless_inject_queue_inj_fifo
//
// Circular FIFO used as the injection buffer storage. Holds whole flits,
// tracks write/read pointers and an explicit occupancy count so that both
// full (count == DEPTH) and empty (count == 0) are unambiguous.
//
// Parameters:
//   DEPTH : number of entries, power of two, >= 2
//   PTR_W : log2(DEPTH)
//   W     : entry width in bits
//
// Ports:
//   clk_i    : clock, all state on the rising edge
//   rst_ni   : asynchronous active-low reset (pointers and count only)
//   push_i   : write wdata_i at the tail (ignored while full)
//   pop_i    : drop the head entry (ignored while empty)
//   wdata_i  : entry to store on push
//   full_o   : count == DEPTH
//   empty_o  : count == 0
//   count_o  : number of stored entries, 0..DEPTH
//   head_o   : oldest stored entry (undefined content while empty)
//
// Push and pop in the same cycle are both honoured; the pop consumes the old
// head and the count is unchanged. There is no write-to-read bypass: a flit
// written into an empty FIFO appears on head_o only after the clock edge.
// -----------------------------------------------------------------------------
module bless_inject_queue_inj_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 40
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o,
  output logic [W-1:0]     head_o
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic full, empty;
  logic push_ok, pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);

  // Guard against over/underflow here as well, so the storage stays coherent
  // even if a caller ever drives push on full or pop on empty.
  assign push_ok = push_i & ~full;
  assign pop_ok  = pop_i  & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: clearing the count is enough to discard every
  // stored flit, and the head is masked by the caller whenever empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bless_inject_queue.sv
// -----------------------------------------------------------------------------
// bless_inject_queue
//
// Local-node injection buffer placed directly upstream of the BLESS router's
// local port (port 4). Flits from the core are queued in a small FIFO; the
// head flit is presented on the router's port-4 inputs only in cycles where
// the router grants injection (port4_ready). The router latches port 4 every
// cycle, so in any non-granted cycle the port-4 outputs are all zero and the
// head simply waits for a later grant.
//
// Optional feature macro: BLESS_INJ_STARVE_EN
//   defined   : starvation counter counts consecutive cycles in which a flit
//               waits but is denied; saturates at STARVE_MAX, raises starved.
//   undefined : starve_cnt and starved are constant 0, no counter registers.
//
// Parameters:
//   DEPTH      : FIFO entries (power of two, >= 2)
//   PTR_W      : log2(DEPTH)
//   STARVE_MAX : starvation counter saturation value (macro builds only)
//
// Ports:
//   clk         : clock
//   rst         : asynchronous active-low reset
//   core_ci     : flit control word from the core (valid bit ignored)
//   core_di     : flit payload from the core
//   core_valid  : core offers a flit
//   core_ready  : queue can accept a flit (not full, not in reset)
//   port4_ready : router grants local injection this cycle (combinational)
//   port4_ci    : control word to router port 4 (valid only on injection)
//   port4_di    : payload to router port 4 (zero unless injecting)
//   inj_fire    : head flit consumed this cycle
//   occupancy   : number of stored flits
//   starve_cnt  : consecutive denied cycles with a flit waiting
//   starved     : starve_cnt has saturated
//
// Handshakes:
//   core side : a flit is transferred on a rising edge where core_valid and
//               core_ready are both high. core_ready depends only on the
//               stored count (and reset), never on port4_ready, so a pop in
//               a full cycle does not open a push in that same cycle.
//   port 4    : injection happens in any cycle where port4_ready is high and
//               the queue is non-empty; inj_fire reports it and port4_ci
//               carries the valid flag only then. port4_ready -> port4_* /
//               inj_fire is combinational; core_* never reaches port4_*
//               combinationally.
// -----------------------------------------------------------------------------
module bless_inject_queue
  import bless_inject_queue_pkg::*;
#(
  parameter int DEPTH      = INJ_DEPTH,
  parameter int PTR_W      = INJ_PTR_W
`ifdef BLESS_INJ_STARVE_EN
  ,
  parameter int STARVE_MAX = INJ_STARVE_MAX
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CONTROL_W-1:0] core_ci,
  input  logic [DATA_W-1:0]    core_di,
  input  logic                 core_valid,
  output logic                 core_ready,
  input  logic                 port4_ready,
  output logic [CONTROL_W-1:0] port4_ci,
  output logic [DATA_W-1:0]    port4_di,
  output logic                 inj_fire,
  output logic [PTR_W:0]       occupancy,
  output logic [STARVE_W-1:0]  starve_cnt,
  output logic                 starved
);

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic [PTR_W:0] count;
  flit_t          wr_flit;
  flit_t          head;

  // Reset is folded into the handshakes so that nothing is accepted or
  // presented while rst is low, independent of the clock.
  assign core_ready = rst & ~full;
  assign push       = core_valid & core_ready;
  assign pop        = port4_ready & ~empty & rst;

  assign wr_flit.ctrl = core_ci;
  assign wr_flit.data = core_di;

  bless_inject_queue_inj_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (FLIT_W)
  ) u_inj_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_flit),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

  // Valid masking: the head only ever appears on port 4 in the cycle it is
  // consumed. Every other cycle drives a zero flit, which the router treats
  // as an empty slot.
  always_comb begin
    port4_ci = '0;
    port4_di = '0;
    if (pop) begin
      port4_ci = set_valid(head.ctrl);
      port4_di = head.data;
    end
  end

  assign inj_fire  = pop;
  assign occupancy = count;

`ifdef BLESS_INJ_STARVE_EN
  localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;

  // Counts cycles where a flit waits but the router refuses it. Any
  // injection or an empty queue restarts the count; it sticks at the
  // saturation value so starved stays asserted until relief arrives.
  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (!port4_ready && (starve_q != STARVE_SAT)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign starve_cnt = starve_q;
  assign starved    = (starve_q == STARVE_SAT);
`else
  assign starve_cnt = '0;
  assign starved    = 1'b0;
`endif

endmodule

// File: tb/tb_bless_inject_queue.sv
// -----------------------------------------------------------------------------
// tb_bless_inject_queue
//
// Directed plus short random bench for bless_inject_queue. A queue-based
// reference model (exp_q) receives every flit the core hands over and yields
// the flit expected on port 4 whenever an injection should occur. Outputs are
// sampled on the falling edge; inputs change 1 time unit after the rising
// edge. Starvation expectations follow BLESS_INJ_STARVE_EN like the design.
// -----------------------------------------------------------------------------
module tb_bless_inject_queue;
  import bless_inject_queue_pkg::*;

  localparam int FW = CONTROL_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CONTROL_W-1:0] core_ci;
  logic [DATA_W-1:0]    core_di;
  logic                 core_valid;
  logic                 core_ready;
  logic                 port4_ready;
  logic [CONTROL_W-1:0] port4_ci;
  logic [DATA_W-1:0]    port4_di;
  logic                 inj_fire;
  logic [INJ_PTR_W:0]   occupancy;
  logic [STARVE_W-1:0]  starve_cnt;
  logic                 starved;

  bless_inject_queue dut (
    .clk         (clk),
    .rst         (rst),
    .core_ci     (core_ci),
    .core_di     (core_di),
    .core_valid  (core_valid),
    .core_ready  (core_ready),
    .port4_ready (port4_ready),
    .port4_ci    (port4_ci),
    .port4_di    (port4_di),
    .inj_fire    (inj_fire),
    .occupancy   (occupancy),
    .starve_cnt  (starve_cnt),
    .starved     (starved)
  );

  // ---------------- scoreboard ----------------
  logic [FW-1:0]        exp_q[$];
  logic [STARVE_W-1:0]  exp_starve = '0;
  logic [CONTROL_W-1:0] vmask;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare every output against the model at the falling
  // edge, advance the model as the rising edge will, then return 1 unit
  // after the rising edge so the caller can change inputs.
  task automatic step();
    logic [FW-1:0] head;
    logic          exp_fire;
    int            sz;
    @(negedge clk);
    if (!rst) begin
      exp_q.delete();
      exp_starve = '0;
    end
    sz       = exp_q.size();
    exp_fire = rst && port4_ready && (sz != 0);
    check("core_ready", 64'(core_ready), 64'(rst && (sz != INJ_DEPTH)));
    check("occupancy",  64'(occupancy),  64'(sz));
    check("inj_fire",   64'(inj_fire),   64'(exp_fire));
    if (exp_fire) begin
      head = exp_q.pop_front();
      check("port4_ci", 64'(port4_ci), 64'(head[FW-1:DATA_W] | vmask));
      check("port4_di", 64'(port4_di), 64'(head[DATA_W-1:0]));
    end else begin
      check("port4_ci_idle", 64'(port4_ci), 64'(0));
      check("port4_di_idle", 64'(port4_di), 64'(0));
    end
`ifdef BLESS_INJ_STARVE_EN
    check("starve_cnt", 64'(starve_cnt), 64'(exp_starve));
    check("starved",    64'(starved),    64'(exp_starve == 8'd255));
`else
    check("starve_cnt", 64'(starve_cnt), 64'(0));
    check("starved",    64'(starved),    64'(0));
`endif
    if (!rst || sz == 0 || exp_fire) begin
      exp_starve = '0;
    end else if (!port4_ready && exp_starve != 8'd255) begin
      exp_starve = exp_starve + 8'd1;
    end
    if (rst && core_valid && (sz != INJ_DEPTH)) begin
      exp_q.push_back({core_ci, core_di});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive_flit(input logic [DATA_W-1:0] d);
    core_ci    = CONTROL_W'($urandom);
    core_di    = d;
    core_valid = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vmask       = CONTROL_W'(1) << VALID_F;
    rst         = 1'b0;
    core_ci     = '0;
    core_di     = '0;
    core_valid  = 1'b0;
    port4_ready = 1'b1;

    // Reset, then release with an empty queue and ready high.
    step();
    step();
    rst = 1'b1;
    #1;
    check("rel_port4_ci",  64'(port4_ci),   64'(0));
    check("rel_inj_fire",  64'(inj_fire),   64'(0));
    check("rel_core_ready",64'(core_ready), 64'(1));
    check("rel_occupancy", 64'(occupancy),  64'(0));
    step();

    // Single flit A with ready always high: injected the next cycle.
    core_ci    = 8'h3C;
    core_di    = 32'h0000_00A5;
    core_valid = 1'b1;
    step();
    core_valid = 1'b0;
    check("a_fire",  64'(inj_fire), 64'(1));
    check("a_di",    64'(port4_di), 64'(32'h0000_00A5));
    check("a_ci",    64'(port4_ci), 64'(8'h3D));
    step();
    check("a_once",  64'(inj_fire), 64'(0));
    check("a_empty", 64'(occupancy),64'(0));

    // Fill with ready low, attempt an extra push while full, then drain.
    port4_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_flit(32'h100 + i);
      step();
    end
    check("full_occ",   64'(occupancy),  64'(4));
    check("full_ready", 64'(core_ready), 64'(0));
    check("full_ci",    64'(port4_ci),   64'(0));
    drive_flit(32'hDEAD);
    step();
    core_valid  = 1'b0;
    port4_ready = 1'b1;
    step();
    check("after_pop_ready", 64'(core_ready), 64'(1));
    for (int i = 0; i < 3; i++) step();
    check("drain_occ", 64'(occupancy), 64'(0));

    // Occupancy 2 then simultaneous push/pop across pointer wrap.
    port4_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_flit(32'h200 + i);
      step();
    end
    port4_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_flit(32'h300 + i);
      step();
      check("pp_occ", 64'(occupancy), 64'(2));
    end
    core_valid = 1'b0;
    step();
    step();

    // Asynchronous reset in the middle of a burst with 3 stored flits.
    port4_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_flit(32'h400 + i);
      step();
    end
    core_valid  = 1'b0;
    port4_ready = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_starve = '0;
    check("arst_ci",    64'(port4_ci),   64'(0));
    check("arst_di",    64'(port4_di),   64'(0));
    check("arst_fire",  64'(inj_fire),   64'(0));
    check("arst_ready", 64'(core_ready), 64'(0));
    check("arst_occ",   64'(occupancy),  64'(0));
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Starvation: one flit waiting, grant withheld for 300 cycles.
    port4_ready = 1'b0;
    drive_flit(32'h500);
    step();
    core_valid = 1'b0;
    for (int i = 0; i < 300; i++) step();
`ifdef BLESS_INJ_STARVE_EN
    check("starve_sat",  64'(starve_cnt), 64'(255));
    check("starved_hi",  64'(starved),    64'(1));
`else
    check("starve_off",  64'(starve_cnt), 64'(0));
`endif
    port4_ready = 1'b1;
    step();
    check("starve_clr",  64'(starve_cnt), 64'(0));
    check("starved_lo",  64'(starved),    64'(0));

    // Random traffic, then drain.
    for (int i = 0; i < 300; i++) begin
      core_ci     = CONTROL_W'($urandom);
      core_di     = $urandom;
      core_valid  = 1'($urandom_range(0, 1));
      port4_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    core_valid  = 1'b0;
    port4_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("final_occ",   64'(occupancy),    64'(0));
    check("model_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
